// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/WB/SRAM/ID-facing signals of the MEM stage.
// master drives EX handshake, WB back-pressure/flush and SRAM responses.
// slave (mem_stage) returns allowin, the WB bus and ID forwarding/stall info.
interface mem_stage_if;
    logic         es_to_ms_valid;
    logic [141:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [135:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [4:0]   ms_to_ds_dest;
    logic [31:0]  ms_to_ds_value;
    logic         ms_load_block;
    logic         ms_csr;
    logic         ms_ex;
    logic         ws_reflush_ms;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok,
               data_sram_rdata, ws_reflush_ms,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest,
               ms_to_ds_value, ms_load_block, ms_csr, ms_ex
    );

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok,
               data_sram_rdata, ws_reflush_ms,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest,
               ms_to_ds_value, ms_load_block, ms_csr, ms_ex
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Ports: clk, reset (sync, active-high), mif (mem_stage_if.slave): EX handshake/bus in,
// WB handshake/136-bit bus out, data-SRAM response in, ID forwarding/stall info out, WB flush in.
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    mif
);
    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

    logic                ms_valid_q, ms_valid_d;
    logic [141:0]        bus_q, bus_d;
    logic [31:0]         data_buf_q, data_buf_d;
    logic                data_buf_valid_q, data_buf_valid_d;
    logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

    logic        mem_req, resp_ok, ready_go, allowin, accept, capture, is_load, inc, dec;
    logic [2:0]  ld_op;
    logic [1:0]  addr;
    logic [31:0] rdat, shifted, load_val, final_result;
    logic [15:0] half;
    logic [7:0]  byte_v;

    assign mem_req  = bus_q[141];
    assign ld_op    = bus_q[140:138];
    assign addr     = bus_q[137:136];
    assign is_load  = ld_op != 3'd0 && ld_op <= 3'd5;
    // A response only belongs to us once every response of a flushed instruction has drained.
    assign resp_ok  = mif.data_sram_data_ok && cancel_cnt_q == '0;
    assign ready_go = !mem_req || data_buf_valid_q || resp_ok;
    assign allowin  = !ms_valid_q || (ready_go && mif.ws_allowin);
    assign accept   = mif.es_to_ms_valid && allowin;
    assign capture  = resp_ok && ms_valid_q && mem_req && !mif.ws_allowin;
    // Flushing an instruction still waiting on the SRAM leaves one response in flight to discard.
    assign inc      = mif.ws_reflush_ms && ms_valid_q && mem_req && !data_buf_valid_q && !resp_ok;
    assign dec      = mif.data_sram_data_ok && cancel_cnt_q != '0;

    assign rdat     = data_buf_valid_q ? data_buf_q : mif.data_sram_rdata;
    assign shifted  = rdat >> {addr, 3'b000};
    assign byte_v   = shifted[7:0];
    assign half     = addr[1] ? rdat[31:16] : rdat[15:0];
    assign load_val = ld_op == 3'd1 ? {{24{byte_v[7]}}, byte_v} :
                      ld_op == 3'd2 ? {24'd0, byte_v} :
                      ld_op == 3'd3 ? {{16{half[15]}}, half} :
                      ld_op == 3'd4 ? {16'd0, half} : rdat;
    assign final_result = is_load ? load_val : bus_q[63:32];

    always_comb begin
        ms_valid_d       = mif.ws_reflush_ms ? 1'b0 : allowin ? mif.es_to_ms_valid : ms_valid_q;
        bus_d            = accept ? mif.es_to_ms_bus : bus_q;
        data_buf_d       = capture ? mif.data_sram_rdata : data_buf_q;
        data_buf_valid_d = accept ? 1'b0 : capture ? 1'b1 : data_buf_valid_q;
        cancel_cnt_d     = (inc && !dec && cancel_cnt_q != CNT_MAX) ? cancel_cnt_q + CANCEL_W'(1) :
                           (dec && !inc) ? cancel_cnt_q - CANCEL_W'(1) : cancel_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q       <= 1'b0;
            data_buf_valid_q <= 1'b0;
            cancel_cnt_q     <= '0;
        end else begin
            ms_valid_q       <= ms_valid_d;
            data_buf_valid_q <= data_buf_valid_d;
            cancel_cnt_q     <= cancel_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q      <= bus_d;
        data_buf_q <= data_buf_d;
    end

    assign mif.ms_allowin     = allowin;
    assign mif.ms_to_ws_valid = ms_valid_q && ready_go && !mif.ws_reflush_ms;
    assign mif.ms_to_ws_bus   = {bus_q[135:64], final_result, bus_q[31:0]};
    assign mif.ms_to_ds_dest  = (ms_valid_q && bus_q[69]) ? bus_q[68:64] : 5'd0;
    assign mif.ms_to_ds_value = (ms_valid_q && bus_q[69]) ? final_result : 32'd0;
    assign mif.ms_load_block  = ms_valid_q && is_load && !(data_buf_valid_q || resp_ok);
    assign mif.ms_csr         = ms_valid_q && (bus_q[134] || bus_q[133]);
    assign mif.ms_ex          = ms_valid_q && (bus_q[135] || |bus_q[86:70]);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a field-level reference model.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_stage_if m_if();
    mem_stage #(.CANCEL_W(2)) dut (.clk(clk), .reset(reset), .mif(m_if));

    function automatic logic [141:0] mk(logic mr, logic [2:0] op, logic [1:0] a, logic [31:0] fr,
                                        logic [4:0] dest, logic gw, logic [16:0] exc,
                                        logic [2:0] csr3, logic [31:0] pc);
        return {mr, op, a, csr3, pc ^ 32'h0F0F_0000, 14'h0AB, exc, gw, dest, fr, pc};
    endfunction

    function automatic logic [31:0] exp_final(logic [2:0] op, logic [1:0] a, logic [31:0] rd, logic [31:0] fr);
        int unsigned bv, hv;
        bv = (rd >> (8 * int'(a))) % 256;
        hv = (a >= 2) ? rd / 65536 : rd % 65536;
        case (op)
            3'd1: return bv < 128 ? 32'(bv) : 32'(bv) - 32'd256;
            3'd2: return 32'(bv);
            3'd3: return hv < 32768 ? 32'(hv) : 32'(hv) - 32'd65536;
            3'd4: return 32'(hv);
            3'd5: return rd;
            default: return fr;
        endcase
    endfunction

    function automatic logic [135:0] exp_bus(logic [141:0] b, logic [31:0] rd);
        return {b[135:64], exp_final(b[140:138], b[137:136], rd, b[63:32]), b[31:0]};
    endfunction

    task automatic chk(string tag, logic [135:0] obs, logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(logic [141:0] b);
        m_if.es_to_ms_valid = 1'b1;
        m_if.es_to_ms_bus   = b;
        tick();
        m_if.es_to_ms_valid = 1'b0;
    endtask

    task automatic do_load(string tag, logic [2:0] op, logic [1:0] a, logic [31:0] rd, logic [31:0] exp);
        enter(mk(1'b1, op, a, $urandom, 5'd7, 1'b1, 17'd0, 3'd0, $urandom));
        #1;
        chk({tag, "_blk0"}, m_if.ms_load_block, 1);
        chk({tag, "_wait0"}, m_if.ms_to_ws_valid, 0);
        tick();
        #1;
        chk({tag, "_blk1"}, m_if.ms_load_block, 1);
        tick();
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = rd;
        #1;
        chk({tag, "_valid"}, m_if.ms_to_ws_valid, 1);
        chk({tag, "_result"}, m_if.ms_to_ws_bus[63:32], exp);
        chk({tag, "_fwd"}, m_if.ms_to_ds_value, exp);
        chk({tag, "_blk_off"}, m_if.ms_load_block, 0);
        tick();
        m_if.data_sram_data_ok = 1'b0;
        #1;
        chk({tag, "_gone"}, m_if.ms_to_ws_valid, 0);
    endtask

    initial begin
        logic [141:0] b;
        logic [31:0]  rd;
        logic         mr, got, done;
        logic [2:0]   op;
        int           lat;

        m_if.es_to_ms_valid    = 1'b0;
        m_if.es_to_ms_bus      = '0;
        m_if.ws_allowin        = 1'b1;
        m_if.data_sram_data_ok = 1'b0;
        m_if.data_sram_rdata   = '0;
        m_if.ws_reflush_ms     = 1'b0;
        tick();
        tick();
        chk("rst_allowin", m_if.ms_allowin, 1);
        chk("rst_valid", m_if.ms_to_ws_valid, 0);
        chk("rst_dest", m_if.ms_to_ds_dest, 0);
        chk("rst_ex", m_if.ms_ex, 0);
        reset = 1'b0;
        tick();

        // ALU op passes through in one cycle
        b = mk(1'b0, 3'd0, 2'd0, 32'h1234_5678, 5'd5, 1'b1, 17'd0, 3'd0, 32'h1C00_0000);
        enter(b);
        #1;
        chk("alu_valid", m_if.ms_to_ws_valid, 1);
        chk("alu_bus", m_if.ms_to_ws_bus, exp_bus(b, 32'd0));
        chk("alu_dest", m_if.ms_to_ds_dest, 5);
        chk("alu_value", m_if.ms_to_ds_value, 32'h1234_5678);
        chk("alu_blk", m_if.ms_load_block, 0);
        tick();
        #1;
        chk("alu_gone", m_if.ms_to_ws_valid, 0);
        tick();

        do_load("ldb", 3'd1, 2'b11, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("ldbu", 3'd2, 2'b11, 32'h80FF_0000, 32'h0000_0080);
        do_load("ldh", 3'd3, 2'b10, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("ldhu", 3'd4, 2'b10, 32'h8001_7FFF, 32'h0000_8001);
        do_load("ldw", 3'd5, 2'b10, 32'h8001_7FFF, 32'h8001_7FFF);
        do_load("ldh_lo", 3'd3, 2'b00, 32'h8001_7FFF, 32'h0000_7FFF);

        // Flush while waiting; the flushed load's response must be dropped
        tick();
        enter(mk(1'b1, 3'd5, 2'd0, 32'd0, 5'd3, 1'b1, 17'd0, 3'd0, 32'h100));
        tick();
        m_if.ws_reflush_ms = 1'b1;
        #1;
        chk("fl_valid", m_if.ms_to_ws_valid, 0);
        tick();
        m_if.ws_reflush_ms = 1'b0;
        #1;
        chk("fl_empty", m_if.ms_allowin, 1);
        enter(mk(1'b1, 3'd5, 2'd0, 32'd0, 5'd3, 1'b1, 17'd0, 3'd0, 32'h104));
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("fl_stale_valid", m_if.ms_to_ws_valid, 0);
        chk("fl_stale_blk", m_if.ms_load_block, 1);
        tick();
        m_if.data_sram_data_ok = 1'b0;
        #1;
        chk("fl_still_blk", m_if.ms_load_block, 1);
        tick();
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = 32'h0000_0042;
        #1;
        chk("fl_new_valid", m_if.ms_to_ws_valid, 1);
        chk("fl_new_result", m_if.ms_to_ws_bus[63:32], 32'h42);
        tick();
        m_if.data_sram_data_ok = 1'b0;

        // Flush coinciding with the owned response: consumed, nothing left stale
        enter(mk(1'b1, 3'd5, 2'd0, 32'd0, 5'd3, 1'b1, 17'd0, 3'd0, 32'h108));
        m_if.ws_reflush_ms     = 1'b1;
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = 32'h1111_2222;
        tick();
        m_if.ws_reflush_ms     = 1'b0;
        m_if.data_sram_data_ok = 1'b0;
        enter(mk(1'b1, 3'd5, 2'd0, 32'd0, 5'd3, 1'b1, 17'd0, 3'd0, 32'h10C));
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = 32'h3333_4444;
        #1;
        chk("flok_result", m_if.ms_to_ws_bus[63:32], 32'h3333_4444);
        chk("flok_valid", m_if.ms_to_ws_valid, 1);
        tick();
        m_if.data_sram_data_ok = 1'b0;

        // Response buffered while WB stalls
        enter(mk(1'b1, 3'd5, 2'd0, 32'd0, 5'd9, 1'b1, 17'd0, 3'd0, 32'h200));
        m_if.ws_allowin        = 1'b0;
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        chk("buf_allowin", m_if.ms_allowin, 0);
        tick();
        m_if.data_sram_data_ok = 1'b0;
        m_if.data_sram_rdata   = 32'h1111_1111;
        #1;
        chk("buf_hold_valid", m_if.ms_to_ws_valid, 1);
        chk("buf_hold_result", m_if.ms_to_ws_bus[63:32], 32'hCAFE_F00D);
        chk("buf_hold_blk", m_if.ms_load_block, 0);
        tick();
        m_if.data_sram_rdata = 32'h2222_2222;
        m_if.ws_allowin      = 1'b1;
        #1;
        chk("buf_fwd_result", m_if.ms_to_ws_bus[63:32], 32'hCAFE_F00D);
        chk("buf_fwd_allowin", m_if.ms_allowin, 1);
        tick();
        #1;
        chk("buf_gone", m_if.ms_to_ws_valid, 0);

        // Exception-carrying instruction
        enter(mk(1'b0, 3'd0, 2'd0, 32'h5, 5'd0, 1'b0, 17'h2, 3'b010, 32'h300));
        #1;
        chk("exc_ex", m_if.ms_ex, 1);
        chk("exc_valid", m_if.ms_to_ws_valid, 1);
        chk("exc_csr", m_if.ms_csr, 1);
        tick();
        enter(mk(1'b0, 3'd0, 2'd0, 32'h5, 5'd0, 1'b0, 17'h0, 3'b100, 32'h304));
        #1;
        chk("ertn_ex", m_if.ms_ex, 1);
        chk("ertn_csr", m_if.ms_csr, 0);
        tick();

        // Reset mid-wait, after a flush left a pending cancel
        enter(mk(1'b1, 3'd1, 2'd0, 32'd0, 5'd4, 1'b1, 17'd0, 3'b010, 32'h400));
        m_if.ws_reflush_ms = 1'b1;
        tick();
        m_if.ws_reflush_ms = 1'b0;
        enter(mk(1'b1, 3'd1, 2'd0, 32'd0, 5'd4, 1'b1, 17'h4, 3'b010, 32'h404));
        reset = 1'b1;
        tick();
        #1;
        chk("rstw_allowin", m_if.ms_allowin, 1);
        chk("rstw_valid", m_if.ms_to_ws_valid, 0);
        chk("rstw_dest", m_if.ms_to_ds_dest, 0);
        chk("rstw_value", m_if.ms_to_ds_value, 0);
        chk("rstw_blk", m_if.ms_load_block, 0);
        chk("rstw_csr", m_if.ms_csr, 0);
        chk("rstw_ex", m_if.ms_ex, 0);
        reset = 1'b0;
        tick();
        enter(mk(1'b1, 3'd5, 2'd0, 32'd0, 5'd4, 1'b1, 17'd0, 3'd0, 32'h408));
        m_if.data_sram_data_ok = 1'b1;
        m_if.data_sram_rdata   = 32'h5555_AAAA;
        #1;
        chk("rstw_cnt_clear", m_if.ms_to_ws_valid, 1);
        chk("rstw_new_result", m_if.ms_to_ws_bus[63:32], 32'h5555_AAAA);
        tick();
        m_if.data_sram_data_ok = 1'b0;

        // Randomized single-instruction traffic with random SRAM latency and WB stalls
        for (int n = 0; n < 200; n++) begin
            mr = 1'($urandom_range(0, 1));
            op = mr ? 3'($urandom_range(0, 7)) : 3'd0;
            b  = mk(mr, op, 2'($urandom), $urandom, 5'($urandom), 1'($urandom), 17'd0, 3'd0, $urandom);
            enter(b);
            lat  = $urandom_range(0, 3);
            got  = !mr;
            done = 1'b0;
            rd   = '0;
            for (int c = 0; c < 20 && !done; c++) begin
                m_if.ws_allowin        = (c >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                m_if.data_sram_rdata   = $urandom;
                m_if.data_sram_data_ok = mr && !got && c == lat;
                if (m_if.data_sram_data_ok) begin
                    got = 1'b1;
                    rd  = m_if.data_sram_rdata;
                end
                #1;
                chk("rnd_valid", m_if.ms_to_ws_valid, got);
                chk("rnd_blk", m_if.ms_load_block, op >= 3'd1 && op <= 3'd5 && !got);
                if (got) chk("rnd_bus", m_if.ms_to_ws_bus, exp_bus(b, rd));
                done = got && m_if.ws_allowin;
                tick();
            end
            m_if.data_sram_data_ok = 1'b0;
            m_if.ws_allowin        = 1'b1;
            chk("rnd_timeout", done, 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
